csr_bank: RTL and testbench
===========================

Name: csr_bank

Overview:
- Parametrised successor of the checker CSR block.
- Provides an Avalon-MM slave register bank in the system clock domain with a parameterised number of test-parameter and result registers, and byte-enable writes.
- Adds a sys-domain test-control FSM (busy/done tracking, abort command, error flags, interrupt) and handshaked start/abort/finish crossings to the memory-clock checker.
- Sits between the host Avalon-MM interconnect and the memory checker core.

Parameters:
- DATA_W, 32: register and bus data width; must be a multiple of 8.
- ADDR_W, 5: Avalon word-address width.
- PARAM_REGS, 8: number of read-write test-parameter registers.
- RESULT_REGS, 6: number of read-only result registers.
- Elaboration check: 2 + PARAM_REGS + RESULT_REGS <= 2**ADDR_W.

Ports:
- clk_sys_i  in  1  system clock
- rst_sys_i  in  1  system reset
- clk_mem_i  in  1  memory/checker clock
- rst_mem_i  in  1  memory-domain reset, asynchronous, active-high
- read_i  in  1  Avalon read
- write_i  in  1  Avalon write
- address_i  in  ADDR_W  word address
- writedata_i  in  DATA_W  write data
- byteenable_i  in  DATA_W/8  write byte lanes
- readdatavalid_o  out  1  read data valid
- readdata_o  out  DATA_W  read data
- irq_o  out  1  level interrupt, sys domain
- test_finished_i  in  1  mem-domain single-cycle pulse: test complete
- test_result_i  in  RESULT_REGS x DATA_W  mem-domain results; held stable from test_finished_i until the next test_start_o
- test_start_o  out  1  mem-domain single-cycle start pulse
- test_abort_o  out  1  mem-domain single-cycle abort pulse
- test_param_o  out  PARAM_REGS x DATA_W  parameter registers, sys domain; quasi-static while busy

Interface rule: reset rst_sys_i, asynchronous, active-high; clock clk_sys_i. All CSR, FSM and Avalon logic is in this domain. Only the mem halves of the pulse synchronisers use clk_mem_i/rst_mem_i.

Behaviour:
- Address map:
  - 0 CTRL: bit0 START, write-1 self-clearing, reads 0; bit1 ABORT, write-1, reads 0; bit2 IRQ_EN, RW.
  - 1 STATUS, RO: bit0 BUSY; bit1 DONE, sticky, clear-on-read; bit2 ERR, sticky, clear-on-read.
  - 2 .. 1+PARAM_REGS: parameters.
  - Next RESULT_REGS addresses: results.
  - Remaining addresses: unmapped.
- Reset values: all registers, readdata_o, readdatavalid_o, irq_o, test_start_o and test_abort_o are 0; FSM is in IDLE.
- Reads:
  - readdatavalid_o = registered read_i, so fixed 1-cycle latency.
  - readdata_o is registered from the address sampled with read_i.
  - Unmapped read returns 0 and sets ERR.
- Writes:
  - Applied per byte lane using byteenable_i.
  - Writes to RO or unmapped addresses are dropped and set ERR.
  - Parameter writes while BUSY are dropped and set ERR.
- read_i and write_i asserted in the same cycle: the write executes, the read is ignored, no readdatavalid_o, ERR is set.
- FSM states: IDLE, START_PEND, RUN.
  - IDLE: START=1 toggles the start synchroniser and moves to START_PEND. BUSY=1 in every state except IDLE.
  - START_PEND: stays until the mem-side acknowledge toggle returns through the 2-FF sync, then moves to RUN.
  - RUN: on the synchronised finish strobe, capture test_result_i into the result registers, set DONE, move to IDLE.
- START written while not IDLE: ignored, sets ERR.
- ABORT:
  - In RUN: sends one test_abort_o pulse; the FSM stays in RUN until finish.
  - In START_PEND: recorded and sent immediately after the ack.
  - In IDLE: sets ERR.
- Finish strobe in IDLE or START_PEND (spurious): no result capture, sets ERR.
- DONE set coincident with a STATUS read: the read returns the old value; set has priority, so DONE stays 1.
- irq_o = IRQ_EN & (DONE | ERR), registered, so one cycle after the flag.
- Latency:
  - START write to test_start_o: at most 3 clk_mem_i cycles after the toggle.
  - test_finished_i to DONE: at most 4 clk_sys_i cycles.
- Reset mid-operation:
  - rst_sys_i returns the FSM to IDLE and clears toggles; a later mem-side finish is then treated as spurious (sets ERR).
  - rst_mem_i alone: the sys side stays in START_PEND/RUN until ABORT then rst_sys_i, or until a finish arrives.

Decomposition:
- Shared package rtl_settings_pkg receives:
  - CSR_CTRL and CSR_STATUS indices.
  - CTRL/STATUS bit-position constants.
  - typedef csr_fsm_t enum {IDLE, START_PEND, RUN}.
  - A function computing the parameter/result base addresses from PARAM_REGS.
- Sub-module pulse_sync: toggle-based pulse crossing (source toggle, 2-FF sync, edge detect) with an optional ack toggle back to the source domain.
  - Three instances: start (with ack), abort, finish.

Test Plan:
- Reset, then read STATUS and every mapped address -> readdatavalid_o one cycle after read_i; all data 0x00000000.
- Write param[0]=0xA5A5A5A5 with byteenable_i=4'b0101, prior value 0 -> readback 0x00A500A5; test_param_o[0] matches.
- Write CTRL=0x5 (START and IRQ_EN) -> one test_start_o pulse in the mem domain; BUSY=1. Then pulse test_finished_i with result[0]=0x12345678 -> DONE=1, irq_o=1, result[0] reads 0x12345678. Second STATUS read -> DONE=0, BUSY=0, irq_o=0.
- While in RUN: write param[1] and START -> both dropped, ERR=1, param[1] unchanged. Then write ABORT -> exactly one test_abort_o pulse.
- Read unmapped address 2**ADDR_W-1 -> readdata 0, ERR=1. Assert read_i and write_i together -> write applied, no readdatavalid_o.
- Assert rst_sys_i while in RUN, then pulse test_finished_i -> FSM IDLE, results not captured, ERR=1.

Source files
------------

// File: rtl/rtl_settings_pkg.sv
// Shared CSR map, bit positions and FSM encoding for the checker control bank.
package rtl_settings_pkg;

  localparam int unsigned CSR_CTRL       = 0;
  localparam int unsigned CSR_STATUS     = 1;
  localparam int unsigned CSR_PARAM_BASE = 2;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_ABORT_BIT  = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;
  localparam int unsigned STATUS_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    START_PEND = 2'd1,
    RUN        = 2'd2
  } csr_fsm_t;

  function automatic int unsigned csr_param_base();
    return CSR_PARAM_BASE;
  endfunction

  function automatic int unsigned csr_result_base(input int unsigned param_regs);
    return CSR_PARAM_BASE + param_regs;
  endfunction

  // First address past the mapped register window.
  function automatic int unsigned csr_map_end(input int unsigned param_regs,
                                              input int unsigned result_regs);
    return csr_result_base(param_regs) + result_regs;
  endfunction

endpackage

// File: rtl/pulse_sync.sv
// Toggle-based single-cycle pulse crossing with optional acknowledge toggle
// returned to the source domain.
module pulse_sync #(
  parameter bit ACK_EN = 1'b0
) (
  input  logic clk_src_i,
  input  logic rst_src_i,
  input  logic clk_dst_i,
  input  logic rst_dst_i,
  input  logic pulse_i,
  output logic pulse_o,
  output logic ack_o
);

  logic src_tog_q;
  logic dst_s1_q, dst_s2_q, dst_tog_q;

  // Source toggle flips once per request pulse.
  always_ff @(posedge clk_src_i or posedge rst_src_i) begin
    if (rst_src_i) src_tog_q <= 1'b0;
    else           src_tog_q <= src_tog_q ^ pulse_i;
  end

  // Two-flop synchroniser, edge detect and registered output pulse.
  always_ff @(posedge clk_dst_i or posedge rst_dst_i) begin
    if (rst_dst_i) begin
      dst_s1_q  <= 1'b0;
      dst_s2_q  <= 1'b0;
      dst_tog_q <= 1'b0;
      pulse_o   <= 1'b0;
    end else begin
      dst_s1_q  <= src_tog_q;
      dst_s2_q  <= dst_s1_q;
      dst_tog_q <= dst_s2_q;
      pulse_o   <= dst_s2_q ^ dst_tog_q;
    end
  end

  if (ACK_EN) begin : g_ack
    logic ack_s1_q, ack_s2_q, ack_tog_q;

    // Return the destination-side toggle and edge-detect it in the source domain.
    always_ff @(posedge clk_src_i or posedge rst_src_i) begin
      if (rst_src_i) begin
        ack_s1_q  <= 1'b0;
        ack_s2_q  <= 1'b0;
        ack_tog_q <= 1'b0;
      end else begin
        ack_s1_q  <= dst_tog_q;
        ack_s2_q  <= ack_s1_q;
        ack_tog_q <= ack_s2_q;
      end
    end

    assign ack_o = ack_s2_q ^ ack_tog_q;
  end else begin : g_no_ack
    assign ack_o = 1'b0;
  end

endmodule

// File: rtl/csr_bank.sv
// Avalon-MM CSR bank with test-control FSM and crossings to the memory checker.
module csr_bank
  import rtl_settings_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned PARAM_REGS  = 8,
  parameter int unsigned RESULT_REGS = 6
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_sys_i,
  input  logic                          clk_mem_i,
  input  logic                          rst_mem_i,
  input  logic                          read_i,
  input  logic                          write_i,
  input  logic [ADDR_W-1:0]             address_i,
  input  logic [DATA_W-1:0]             writedata_i,
  input  logic [DATA_W/8-1:0]           byteenable_i,
  output logic                          readdatavalid_o,
  output logic [DATA_W-1:0]             readdata_o,
  output logic                          irq_o,
  input  logic                          test_finished_i,
  input  logic [RESULT_REGS*DATA_W-1:0] test_result_i,
  output logic                          test_start_o,
  output logic                          test_abort_o,
  output logic [PARAM_REGS*DATA_W-1:0]  test_param_o
);

  localparam int unsigned RES_BASE = csr_result_base(PARAM_REGS);
  localparam int unsigned MAP_END  = csr_map_end(PARAM_REGS, RESULT_REGS);

  if (MAP_END > (2 ** ADDR_W)) begin : g_map_check
    $error("csr_bank: register map does not fit in ADDR_W");
  end
  if ((DATA_W % 8) != 0) begin : g_width_check
    $error("csr_bank: DATA_W must be a multiple of 8");
  end

  csr_fsm_t state_q, state_d;
  logic abort_pend_q, abort_pend_d;
  logic irq_en_q, done_q, err_q;
  logic [DATA_W-1:0] param_q  [PARAM_REGS];
  logic [DATA_W-1:0] result_q [RESULT_REGS];

  logic        busy;
  logic        rd_en, wr_en, rw_clash;
  int unsigned addr_u;
  logic        is_ctrl, is_status, mapped;
  logic [PARAM_REGS-1:0]  param_sel;
  logic [RESULT_REGS-1:0] result_sel;
  logic [DATA_W-1:0]      rd_data;
  logic start_cmd, abort_cmd, ctrl_wr;
  logic start_launch, abort_launch, start_ack, finish_strb;
  logic fsm_err, set_done, capture, err_set, status_rd;

  assign busy     = (state_q != IDLE);
  assign wr_en    = write_i;
  assign rd_en    = read_i & ~write_i;
  assign rw_clash = read_i & write_i;

  // Address decode into one-hot register selects.
  always_comb begin
    addr_u     = 32'(address_i);
    is_ctrl    = (addr_u == CSR_CTRL);
    is_status  = (addr_u == CSR_STATUS);
    param_sel  = '0;
    result_sel = '0;
    for (int unsigned i = 0; i < PARAM_REGS; i++)
      param_sel[i] = (addr_u == csr_param_base() + i);
    for (int unsigned i = 0; i < RESULT_REGS; i++)
      result_sel[i] = (addr_u == RES_BASE + i);
    mapped = is_ctrl | is_status | (|param_sel) | (|result_sel);
  end

  // Read data multiplexer; START/ABORT always read back as 0.
  always_comb begin
    rd_data = '0;
    if (is_ctrl) rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
    if (is_status) begin
      rd_data[STATUS_BUSY_BIT] = busy;
      rd_data[STATUS_DONE_BIT] = done_q;
      rd_data[STATUS_ERR_BIT]  = err_q;
    end
    for (int unsigned i = 0; i < PARAM_REGS; i++)
      if (param_sel[i]) rd_data = param_q[i];
    for (int unsigned i = 0; i < RESULT_REGS; i++)
      if (result_sel[i]) rd_data = result_q[i];
  end

  assign ctrl_wr   = wr_en & is_ctrl & byteenable_i[0];
  assign start_cmd = ctrl_wr & writedata_i[CTRL_START_BIT];
  assign abort_cmd = ctrl_wr & writedata_i[CTRL_ABORT_BIT];
  assign status_rd = rd_en & is_status;

  // Test-control FSM: launch, wait for mem-side ack, run until finish.
  always_comb begin
    state_d      = state_q;
    abort_pend_d = abort_pend_q;
    start_launch = 1'b0;
    abort_launch = 1'b0;
    fsm_err      = 1'b0;
    set_done     = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_cmd) begin
          start_launch = 1'b1;
          state_d      = START_PEND;
        end
        if (abort_cmd || finish_strb) fsm_err = 1'b1;
      end
      START_PEND: begin
        if (start_cmd || finish_strb) fsm_err = 1'b1;
        if (abort_cmd) abort_pend_d = 1'b1;
        // An abort seen before the ack is held back until the checker is running.
        if (start_ack) begin
          state_d      = RUN;
          abort_launch = abort_pend_q | abort_cmd;
          abort_pend_d = 1'b0;
        end
      end
      RUN: begin
        if (start_cmd) fsm_err = 1'b1;
        if (abort_cmd) abort_launch = 1'b1;
        if (finish_strb) begin
          capture  = 1'b1;
          set_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_set = fsm_err | rw_clash
                 | (rd_en & ~mapped)
                 | (wr_en & (is_status | (|result_sel) | ~mapped))
                 | (wr_en & (|param_sel) & busy);

  // CSR state, flags, read port and interrupt.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q         <= IDLE;
      abort_pend_q    <= 1'b0;
      irq_en_q        <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      irq_o           <= 1'b0;
      readdatavalid_o <= 1'b0;
      readdata_o      <= '0;
      for (int unsigned i = 0; i < PARAM_REGS; i++)  param_q[i]  <= '0;
      for (int unsigned i = 0; i < RESULT_REGS; i++) result_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      abort_pend_q    <= abort_pend_d;
      readdatavalid_o <= rd_en;
      if (rd_en) readdata_o <= rd_data;
      if (ctrl_wr) irq_en_q <= writedata_i[CTRL_IRQ_EN_BIT];
      // Set wins over clear-on-read; the read itself returns the pre-set value.
      done_q <= set_done | (done_q & ~status_rd);
      err_q  <= err_set  | (err_q  & ~status_rd);
      irq_o  <= irq_en_q & (done_q | err_q);
      for (int unsigned i = 0; i < PARAM_REGS; i++)
        if (wr_en && param_sel[i] && !busy)
          for (int unsigned b = 0; b < DATA_W / 8; b++)
            if (byteenable_i[b]) param_q[i][b*8 +: 8] <= writedata_i[b*8 +: 8];
      if (capture)
        for (int unsigned i = 0; i < RESULT_REGS; i++)
          result_q[i] <= test_result_i[i*DATA_W +: DATA_W];
    end
  end

  for (genvar g = 0; g < PARAM_REGS; g++) begin : g_param_out
    assign test_param_o[g*DATA_W +: DATA_W] = param_q[g];
  end

  pulse_sync #(.ACK_EN(1'b1)) u_start_sync (
    .clk_src_i (clk_sys_i),
    .rst_src_i (rst_sys_i),
    .clk_dst_i (clk_mem_i),
    .rst_dst_i (rst_mem_i),
    .pulse_i   (start_launch),
    .pulse_o   (test_start_o),
    .ack_o     (start_ack)
  );

  pulse_sync #(.ACK_EN(1'b0)) u_abort_sync (
    .clk_src_i (clk_sys_i),
    .rst_src_i (rst_sys_i),
    .clk_dst_i (clk_mem_i),
    .rst_dst_i (rst_mem_i),
    .pulse_i   (abort_launch),
    .pulse_o   (test_abort_o),
    .ack_o     ()
  );

  pulse_sync #(.ACK_EN(1'b0)) u_finish_sync (
    .clk_src_i (clk_mem_i),
    .rst_src_i (rst_mem_i),
    .clk_dst_i (clk_sys_i),
    .rst_dst_i (rst_sys_i),
    .pulse_i   (test_finished_i),
    .pulse_o   (finish_strb),
    .ack_o     ()
  );

endmodule

// File: tb/tb_csr_bank.sv
// Scoreboard bench for csr_bank: reads push expectations, a monitor pops on readdatavalid_o.
module tb_csr_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PR = 8;
  localparam int RR = 6;

  logic              clk_sys_i = 1'b0;
  logic              rst_sys_i = 1'b1;
  logic              clk_mem_i = 1'b0;
  logic              rst_mem_i = 1'b1;
  logic              read_i = 1'b0;
  logic              write_i = 1'b0;
  logic [AW-1:0]     address_i = '0;
  logic [DW-1:0]     writedata_i = '0;
  logic [DW/8-1:0]   byteenable_i = '0;
  logic              readdatavalid_o;
  logic [DW-1:0]     readdata_o;
  logic              irq_o;
  logic              test_finished_i = 1'b0;
  logic [RR*DW-1:0]  test_result_i = '0;
  logic              test_start_o;
  logic              test_abort_o;
  logic [PR*DW-1:0]  test_param_o;

  always #5 clk_sys_i = ~clk_sys_i;
  always #7 clk_mem_i = ~clk_mem_i;

  csr_bank #(.DATA_W(DW), .ADDR_W(AW), .PARAM_REGS(PR), .RESULT_REGS(RR)) dut (
    .clk_sys_i       (clk_sys_i),
    .rst_sys_i       (rst_sys_i),
    .clk_mem_i       (clk_mem_i),
    .rst_mem_i       (rst_mem_i),
    .read_i          (read_i),
    .write_i         (write_i),
    .address_i       (address_i),
    .writedata_i     (writedata_i),
    .byteenable_i    (byteenable_i),
    .readdatavalid_o (readdatavalid_o),
    .readdata_o      (readdata_o),
    .irq_o           (irq_o),
    .test_finished_i (test_finished_i),
    .test_result_i   (test_result_i),
    .test_start_o    (test_start_o),
    .test_abort_o    (test_abort_o),
    .test_param_o    (test_param_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   cyc;
    string         name;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int          start_cnt = 0;
  int          abort_cnt = 0;

  always @(posedge clk_sys_i) cyc <= cyc + 1;

  always @(negedge clk_mem_i) begin
    if (test_start_o) start_cnt++;
    if (test_abort_o) abort_cnt++;
  end

  // Monitor: every readdatavalid_o must match the oldest outstanding read, one cycle later.
  always @(negedge clk_sys_i) begin
    exp_t e;
    if (readdatavalid_o) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rdv: readdatavalid_o=1 with no read outstanding, data=%h", readdata_o);
      end else begin
        e = sb.pop_front();
        if (readdata_o !== e.data || cyc != e.cyc + 1) begin
          n_err++;
          $display("FAIL %s: got data=%h at cycle %0d, expected data=%h at cycle %0d",
                   e.name, readdata_o, cyc, e.data, e.cyc + 1);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys_i);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    @(negedge clk_sys_i);
    address_i = a;
    read_i    = 1'b1;
    sb.push_back('{data: exp, cyc: cyc, name: nm});
    @(negedge clk_sys_i);
    read_i = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    @(negedge clk_sys_i);
    address_i    = a;
    writedata_i  = d;
    byteenable_i = be;
    write_i      = 1'b1;
    @(negedge clk_sys_i);
    write_i = 1'b0;
  endtask

  // Read and write together: only the write may take effect, no read response.
  task automatic rdwr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    @(negedge clk_sys_i);
    address_i    = a;
    writedata_i  = d;
    byteenable_i = be;
    write_i      = 1'b1;
    read_i       = 1'b1;
    @(negedge clk_sys_i);
    write_i = 1'b0;
    read_i  = 1'b0;
  endtask

  task automatic pulse_finish();
    @(negedge clk_mem_i);
    test_finished_i = 1'b1;
    @(negedge clk_mem_i);
    test_finished_i = 1'b0;
  endtask

  initial begin
    int k;

    // Reset and check every mapped register reads as zero.
    idle(3);
    @(negedge clk_mem_i) rst_mem_i = 1'b0;
    @(negedge clk_sys_i) rst_sys_i = 1'b0;
    idle(2);
    chk("reset_rdv", {31'd0, readdatavalid_o}, 32'd0);
    chk("reset_irq", {31'd0, irq_o}, 32'd0);
    chk("reset_param_o", test_param_o[DW-1:0] | test_param_o[PR*DW-1:PR*DW-DW], 32'd0);
    for (int a = 0; a < 2 + PR + RR; a++) rd(AW'(a), 32'h0, $sformatf("reset_rd_%0d", a));

    // Byte-lane write to param[0].
    wr(5'd2, 32'hA5A5A5A5, 4'b0101);
    rd(5'd2, 32'h00A500A5, "param0_be");
    chk("param0_out", test_param_o[31:0], 32'h00A500A5);

    // Normal start / finish cycle with interrupt.
    wr(5'd0, 32'h5, 4'hF);
    idle(20);
    chk("start_pulses_1", 32'(start_cnt), 32'd1);
    rd(5'd0, 32'h4, "ctrl_irq_en");
    rd(5'd1, 32'h1, "status_busy");
    chk("irq_before_done", {31'd0, irq_o}, 32'd0);
    test_result_i[31:0]        = 32'h12345678;
    test_result_i[RR*DW-1 -: DW] = 32'hCAFEF00D;
    pulse_finish();
    idle(10);
    chk("irq_done", {31'd0, irq_o}, 32'd1);
    rd(5'd1, 32'h2, "status_done");
    rd(5'd10, 32'h12345678, "result0");
    rd(5'd15, 32'hCAFEF00D, "result5");
    rd(5'd1, 32'h0, "status_cleared");
    idle(3);
    chk("irq_cleared", {31'd0, irq_o}, 32'd0);

    // Dropped writes while running, then a single abort.
    wr(5'd0, 32'h5, 4'hF);
    idle(20);
    chk("start_pulses_2", 32'(start_cnt), 32'd2);
    wr(5'd3, 32'hDEADBEEF, 4'hF);
    wr(5'd0, 32'h5, 4'hF);
    idle(20);
    chk("no_restart", 32'(start_cnt), 32'd2);
    rd(5'd3, 32'h0, "param1_dropped");
    chk("param1_out", test_param_o[63:32], 32'h0);
    rd(5'd1, 32'h5, "status_busy_err");
    wr(5'd0, 32'h6, 4'hF);
    idle(20);
    chk("abort_pulses", 32'(abort_cnt), 32'd1);
    rd(5'd1, 32'h1, "status_still_run");
    test_result_i[31:0] = 32'h0BADCAFE;
    pulse_finish();
    idle(10);
    rd(5'd1, 32'h2, "status_done_2");
    rd(5'd10, 32'h0BADCAFE, "result0_2");

    // Unmapped read and simultaneous read/write.
    rd(5'd31, 32'h0, "unmapped_rd");
    rd(5'd1, 32'h4, "status_err_unmapped");
    rdwr(5'd2, 32'h11223344, 4'hF);
    idle(2);
    rd(5'd2, 32'h11223344, "rdwr_write_applied");
    rd(5'd1, 32'h4, "status_err_rdwr");

    // System reset mid-run, then a finish that must be treated as spurious.
    wr(5'd0, 32'h5, 4'hF);
    idle(20);
    rd(5'd1, 32'h1, "status_run_3");
    @(negedge clk_sys_i) rst_sys_i = 1'b1;
    idle(2);
    rst_sys_i = 1'b0;
    idle(2);
    test_result_i[31:0] = 32'h55555555;
    pulse_finish();
    idle(10);
    rd(5'd1, 32'h4, "status_spurious");
    rd(5'd10, 32'h0, "result0_not_captured");
    rd(5'd0, 32'h0, "ctrl_after_rst");
    rd(5'd2, 32'h0, "param0_after_rst");

    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk_sys_i);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d reads without response, expected 0", sb.size());
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
